// File: rtl/hit_judge_pkg.sv
// -----------------------------------------------------------------------------
// hit_judge_pkg
// Shared definitions for the rhythm-game judge. The VGA and control FSMs reuse
// these too.
//   - game_state_e : judge FSM state encoding
//   - LIVES_DEFAULT, SYNC_STAGES_DEFAULT : default parameter values
//   - NUM_LANES, COMBO_MAX : geometry and the combo saturation limit
//   - one_hot4()   : true when exactly one of four bits is set
// -----------------------------------------------------------------------------
package hit_judge_pkg;

  localparam int NUM_LANES           = 4;
  localparam int LIVES_DEFAULT       = 3;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam logic [7:0] COMBO_MAX   = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_CREDIT1 = 3'd2,
    ST_CREDIT2 = 3'd3,
    ST_OVER    = 3'd4
  } game_state_e;

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
  function automatic logic one_hot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/hit_judge_key_sync_edge.sv
// -----------------------------------------------------------------------------
// key_sync_edge
// Four-lane key synchronizer and press-event detector.
// Each active-low asynchronous key goes through SYNC_STAGES flops and is then
// inverted to give a "pressed" level. A press event is a 0->1 step of that
// level. The event is registered once more, so a key pressed before an edge
// shows up on press_ev SYNC_STAGES+1 cycles later, as a one-cycle pulse.
// Ports:
//   clock    in   clock
//   resetn   in   synchronous active-low reset (keys read as released)
//   key_n    in   [3:0] raw active-low keys, asynchronous
//   press_ev out  [3:0] registered one-cycle press events, one bit per lane
// -----------------------------------------------------------------------------
module key_sync_edge
  import hit_judge_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NUM_LANES-1:0] key_n,
  output logic [NUM_LANES-1:0] press_ev
);

  // Stage 0 is the flop nearest the pin; stage SYNC_STAGES-1 is the safe one.
  logic [SYNC_STAGES-1:0][NUM_LANES-1:0] sync_q, sync_d;
  logic [NUM_LANES-1:0]                  pressed;
  logic [NUM_LANES-1:0]                  prev_q, prev_d;
  logic [NUM_LANES-1:0]                  ev_q, ev_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], key_n};
    pressed = ~sync_q[SYNC_STAGES-1];
    prev_d  = pressed;
    ev_d    = pressed & ~prev_q;
  end

  // Sync flops reset to 1 (released). A key held through reset therefore
  // still produces one event once its low level has crossed the chain.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_q <= '1;
      prev_q <= '0;
      ev_q   <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      ev_q   <= ev_d;
    end
  end

  assign press_ev = ev_q;

endmodule

// File: rtl/hit_judge.sv
// -----------------------------------------------------------------------------
// hit_judge
// Decides whether key presses hit the lowest tile in play. It keeps the lives
// and combo counters and drives the two-cycle score credit.
// Ports:
//   clock        in   single clock
//   resetn       in   synchronous active-low reset
//   startn       in   start button, active-low, synchronous
//   key_n        in   [3:0] lane keys, active-low, asynchronous
//   tile_valid   in   lowest tile exists
//   tile_lane    in   [1:0] lane of that tile
//   tile_in_zone in   tile overlaps the hit zone
//   tile_passed  in   one-cycle pulse: tile left the zone unhit
//   increment    out  high for exactly 2 cycles per hit (score adds 1 per 2)
//   tile_clear   out  one-cycle pulse removing the hit tile (decoded)
//   miss         out  one-cycle pulse per miss
//   lives        out  [1:0] remaining lives
//   combo        out  [7:0] consecutive hits, saturating at 255
//   game_over    out  high while in OVER
// -----------------------------------------------------------------------------
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int LIVES       = LIVES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 startn,
  input  logic [NUM_LANES-1:0] key_n,
  input  logic                 tile_valid,
  input  logic [1:0]           tile_lane,
  input  logic                 tile_in_zone,
  input  logic                 tile_passed,
  output logic                 increment,
  output logic                 tile_clear,
  output logic                 miss,
  output logic [1:0]           lives,
  output logic [7:0]           combo,
  output logic                 game_over
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  function automatic logic [7:0] combo_sat_inc(input logic [7:0] c);
    return (c == COMBO_MAX) ? c : c + 8'd1;
  endfunction

  function automatic logic [1:0] lives_sat_dec(input logic [1:0] l);
    return (l == 2'd0) ? 2'd0 : l - 2'd1;
  endfunction

  logic [NUM_LANES-1:0] press_ev;

  key_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_key_sync_edge (
    .clock    (clock),
    .resetn   (resetn),
    .key_n    (key_n),
    .press_ev (press_ev)
  );

  game_state_e state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  combo_q, combo_d;
  logic        pend_q, pend_d;
  logic        miss_q, miss_d;
  logic        increment_q, increment_d;
  logic        game_over_q, game_over_d;

  logic        hit_qual;
  logic        hit_ok;
  logic        any_ev;

  // Hit qualification comes from registered press events plus the tile
  // descriptor. A pending passed-tile miss owns the first PLAY cycle, so no
  // hit is accepted in that cycle.
  always_comb begin
    any_ev   = (press_ev != '0);
    hit_qual = one_hot4(press_ev) && tile_valid && tile_in_zone &&
               press_ev[tile_lane];
    hit_ok   = (state_q == ST_PLAY) && !pend_q && hit_qual;
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    combo_d = combo_q;
    pend_d  = pend_q;
    miss_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!startn) begin
          state_d = ST_PLAY;
          lives_d = LIVES_INIT;
          combo_d = '0;
          pend_d  = 1'b0;
        end
      end

      ST_PLAY: begin
        if (pend_q || (!hit_ok && (any_ev || tile_passed))) begin
          // One miss per cycle, whatever combination caused it.
          miss_d  = 1'b1;
          pend_d  = 1'b0;
          combo_d = '0;
          lives_d = lives_sat_dec(lives_q);
          state_d = (lives_d == 2'd0) ? ST_OVER : ST_PLAY;
        end else if (hit_ok) begin
          state_d = ST_CREDIT1;
          combo_d = combo_sat_inc(combo_q);
        end
      end

      ST_CREDIT1: begin
        state_d = ST_CREDIT2;
        if (tile_passed) pend_d = 1'b1;
      end

      ST_CREDIT2: begin
        state_d = ST_PLAY;
        if (tile_passed) pend_d = 1'b1;
      end

      ST_OVER: begin
        if (!startn) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state, so they line up with it.
    increment_d = (state_d == ST_CREDIT1) || (state_d == ST_CREDIT2);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      lives_q     <= LIVES_INIT;
      combo_q     <= '0;
      pend_q      <= 1'b0;
      miss_q      <= 1'b0;
      increment_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      combo_q     <= combo_d;
      pend_q      <= pend_d;
      miss_q      <= miss_d;
      increment_q <= increment_d;
      game_over_q <= game_over_d;
    end
  end

  assign increment  = increment_q;
  assign tile_clear = hit_ok;
  assign miss       = miss_q;
  assign lives      = lives_q;
  assign combo      = combo_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_hit_judge.sv
module tb_hit_judge;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       startn = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic       tile_valid = 1'b0;
  logic [1:0] tile_lane = 2'd0;
  logic       tile_in_zone = 1'b0;
  logic       tile_passed = 1'b0;
  logic       increment, tile_clear, miss, game_over;
  logic [1:0] lives;
  logic [7:0] combo;

  int checks = 0;
  int failures = 0;

  hit_judge #(.LIVES(3), .SYNC_STAGES(2)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .startn       (startn),
    .key_n        (key_n),
    .tile_valid   (tile_valid),
    .tile_lane    (tile_lane),
    .tile_in_zone (tile_in_zone),
    .tile_passed  (tile_passed),
    .increment    (increment),
    .tile_clear   (tile_clear),
    .miss         (miss),
    .lives        (lives),
    .combo        (combo),
    .game_over    (game_over)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       fresh;
    logic [3:0] keys;
    logic       tv;
    logic [1:0] lane;
    logic       zone;
    int         tp_at;
    int         e_clear;
    int         e_miss;
    int         e_inc;
    int         e_lives;
    int         e_combo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; startn = 1'b1; key_n = 4'hF;
    tile_valid = 1'b0; tile_in_zone = 1'b0; tile_passed = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    resetn = 1'b1;
  endtask

  task automatic do_start();
    startn = 1'b0;
    @(posedge clock); #1;
    startn = 1'b1;
    @(posedge clock); #1;
  endtask

  // Called just after a rising edge. Keys are held for one sampling edge;
  // tile_passed is pulsed so the DUT samples it at edge tp_at (0 = never).
  task automatic run_window(input logic [3:0] keys, input logic tv,
                            input logic [1:0] lane, input logic zone,
                            input int tp_at,
                            output int n_clear, output int n_miss,
                            output int n_inc, output int f_clear,
                            output int f_inc);
    n_clear = 0; n_miss = 0; n_inc = 0; f_clear = 0; f_inc = 0;
    tile_valid = tv; tile_lane = lane; tile_in_zone = zone;
    key_n = keys; tile_passed = (tp_at == 1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (tile_clear) begin n_clear++; if (f_clear == 0) f_clear = k; end
      if (miss) n_miss++;
      if (increment) begin n_inc++; if (f_inc == 0) f_inc = k; end
      @(posedge clock); #1;
      key_n = 4'hF;
      tile_passed = (tp_at == k + 1);
    end
    tile_valid = 1'b0; tile_in_zone = 1'b0;
  endtask

  task automatic reset_in_credit(input int rst_edge);
    int inc_seen;
    do_reset(); do_start();
    tile_valid = 1'b1; tile_lane = 2'd2; tile_in_zone = 1'b1;
    key_n = 4'b1011;
    inc_seen = 0;
    for (int k = 1; k <= rst_edge; k++) begin
      @(negedge clock);
      if (increment) inc_seen++;
      @(posedge clock); #1;
      key_n = 4'hF;
      if (k + 1 == rst_edge) resetn = 1'b0;
    end
    @(negedge clock);
    chk($sformatf("rstcr%0d_inc_before", rst_edge), inc_seen, rst_edge - 4);
    chk($sformatf("rstcr%0d_inc", rst_edge), int'(increment), 0);
    chk($sformatf("rstcr%0d_lives", rst_edge), int'(lives), 3);
    chk($sformatf("rstcr%0d_combo", rst_edge), int'(combo), 0);
    chk($sformatf("rstcr%0d_gover", rst_edge), int'(game_over), 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    tile_valid = 1'b0;
  endtask

  initial begin
    int nc, nm, ni, fc, fi;

    vecs[0]  = '{1'b1, 4'b1011, 1'b1, 2'd2, 1'b1, 0, 1, 0, 2, 3, 1};
    vecs[1]  = '{1'b0, 4'b0111, 1'b1, 2'd1, 1'b1, 0, 0, 1, 0, 2, 0};
    vecs[2]  = '{1'b0, 4'b1110, 1'b1, 2'd0, 1'b1, 0, 1, 0, 2, 2, 1};
    vecs[3]  = '{1'b0, 4'b0111, 1'b1, 2'd3, 1'b1, 4, 1, 0, 2, 2, 2};
    vecs[4]  = '{1'b0, 4'b1101, 1'b1, 2'd1, 1'b0, 0, 0, 1, 0, 1, 0};
    vecs[5]  = '{1'b1, 4'b1110, 1'b0, 2'd0, 1'b0, 0, 0, 1, 0, 2, 0};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 2, 0, 1, 0, 1, 0};
    vecs[7]  = '{1'b1, 4'b1100, 1'b1, 2'd0, 1'b1, 0, 0, 1, 0, 2, 0};
    vecs[8]  = '{1'b0, 4'b1101, 1'b1, 2'd1, 1'b1, 0, 1, 0, 2, 2, 1};
    vecs[9]  = '{1'b0, 4'b1011, 1'b1, 2'd0, 1'b1, 4, 0, 1, 0, 1, 0};
    vecs[10] = '{1'b1, 4'b1011, 1'b1, 2'd2, 1'b1, 5, 1, 1, 2, 2, 0};
    vecs[11] = '{1'b0, 4'b1111, 1'b1, 2'd3, 1'b1, 0, 0, 0, 0, 2, 0};

    // Reset state
    do_reset();
    @(negedge clock);
    chk("rst_lives", int'(lives), 3);
    chk("rst_combo", int'(combo), 0);
    chk("rst_gover", int'(game_over), 0);
    chk("rst_inc", int'(increment), 0);
    chk("rst_miss", int'(miss), 0);
    chk("rst_clear", int'(tile_clear), 0);
    @(posedge clock); #1;

    // Table-driven single-event vectors
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].fresh) begin do_reset(); do_start(); end
      run_window(vecs[v].keys, vecs[v].tv, vecs[v].lane, vecs[v].zone,
                 vecs[v].tp_at, nc, nm, ni, fc, fi);
      chk($sformatf("v%0d_clear", v), nc, vecs[v].e_clear);
      chk($sformatf("v%0d_miss", v), nm, vecs[v].e_miss);
      chk($sformatf("v%0d_inc", v), ni, vecs[v].e_inc);
      chk($sformatf("v%0d_lives", v), int'(lives), vecs[v].e_lives);
      chk($sformatf("v%0d_combo", v), int'(combo), vecs[v].e_combo);
      chk($sformatf("v%0d_gover", v), int'(game_over), 0);
      if (vecs[v].e_clear != 0) begin
        chk($sformatf("v%0d_clear_lat", v), fc, 4);
        chk($sformatf("v%0d_inc_lat", v), fi, 5);
        chk($sformatf("v%0d_score", v), ni / 2, 1);
      end
    end

    // Three misses -> game over; OVER ignores keys; start returns to IDLE
    do_reset(); do_start();
    for (int m = 0; m < 3; m++) begin
      run_window(4'b1110, 1'b0, 2'd0, 1'b0, 0, nc, nm, ni, fc, fi);
      chk($sformatf("go_miss%0d", m), nm, 1);
      chk($sformatf("go_lives%0d", m), int'(lives), 2 - m);
    end
    chk("go_gover", int'(game_over), 1);
    run_window(4'b1110, 1'b1, 2'd0, 1'b1, 3, nc, nm, ni, fc, fi);
    chk("over_clear", nc, 0);
    chk("over_miss", nm, 0);
    chk("over_inc", ni, 0);
    chk("over_lives", int'(lives), 0);
    chk("over_gover", int'(game_over), 1);
    startn = 1'b0;
    @(posedge clock); #1;
    startn = 1'b1;
    @(negedge clock);
    chk("idle_gover", int'(game_over), 0);
    @(posedge clock); #1;
    run_window(4'b1110, 1'b1, 2'd0, 1'b1, 0, nc, nm, ni, fc, fi);
    chk("idle_clear", nc, 0);
    chk("idle_miss", nm, 0);

    // Reset in CREDIT1 and in CREDIT2, then the judge sits in IDLE
    reset_in_credit(5);
    reset_in_credit(6);
    run_window(4'b1011, 1'b1, 2'd2, 1'b1, 0, nc, nm, ni, fc, fi);
    chk("postrst_clear", nc, 0);
    chk("postrst_inc", ni, 0);

    // Key held through reset release gives exactly one press event
    resetn = 1'b0; key_n = 4'b1011;
    tile_valid = 1'b1; tile_lane = 2'd2; tile_in_zone = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    resetn = 1'b1; startn = 1'b0;
    nc = 0; fc = 0; ni = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (tile_clear) begin nc++; if (fc == 0) fc = k; end
      if (increment) ni++;
      @(posedge clock); #1;
      startn = 1'b1;
    end
    key_n = 4'hF; tile_valid = 1'b0;
    chk("held_clear", nc, 1);
    chk("held_clear_lat", fc, 4);
    chk("held_inc", ni, 2);
    chk("held_combo", int'(combo), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameter: LIVES, 3, misses allowed before game over (1..3).
REQ-002 Parameter: SYNC_STAGES, 2, key synchronizer depth (>=2).
REQ-003 Port: clock  in  1  single clock for all logic.
REQ-004 Port: resetn  in  1  reset, synchronous, active-low.
REQ-005 Port: startn  in  1  start button, active-low, already synchronous to clock.
REQ-006 Port: key_n  in  4  lane keys, active-low, asynchronous; bit i = lane i.
REQ-007 Port: tile_valid  in  1  lowest tile in play exists.
REQ-008 Port: tile_lane  in  2  lane of that tile.
REQ-009 Port: tile_in_zone  in  1  that tile overlaps the hit zone.
REQ-010 Port: tile_passed  in  1  one-cycle pulse: that tile left the hit zone unhit.
REQ-011 Port: increment  out  1  score credit; high exactly 2 consecutive cycles per hit, because the score stage adds 1 per 2 increment-high cycles.
REQ-012 Port: tile_clear  out  1  one-cycle pulse: remove the hit tile.
REQ-013 Port: miss  out  1  one-cycle pulse per miss.
REQ-014 Port: lives  out  2  remaining lives.
REQ-015 Port: combo  out  8  consecutive hits; saturates at 255.
REQ-016 Port: game_over  out  1  high while in OVER.

Function
REQ-017 Each key_n bit passes through SYNC_STAGES flops, then inversion; a press event is a 0->1 transition of the synchronized pressed value; press-to-event latency = SYNC_STAGES+1 cycles.
REQ-018 States: IDLE, PLAY, CREDIT1, CREDIT2, OVER.
REQ-019 IDLE: outputs quiet; startn=0 -> PLAY, lives<=LIVES, combo<=0.
REQ-020 PLAY: hit = exactly one press event, on lane L, with tile_valid=1, tile_in_zone=1 and tile_lane=L.
REQ-021 On hit, in the same cycle: tile_clear pulse; next state CREDIT1; combo<=combo+1, saturating at 255.
REQ-022 CREDIT1 and CREDIT2: increment=1; CREDIT1->CREDIT2->PLAY unconditionally.
REQ-023 Press events during CREDIT1 or CREDIT2 are discarded.
REQ-024 In PLAY, a miss is any of:
- a press event with no hit (wrong lane, no tile, or tile not in zone);
- two or more simultaneous press events;
- tile_passed=1.
REQ-025 Hit and tile_passed in the same cycle: hit wins; no miss.
REQ-026 Miss actions: miss pulse for 1 cycle; combo<=0; lives<=lives-1; if the new lives value is 0 -> OVER, else stay in PLAY.
REQ-027 At most one miss per cycle, even if a key miss and tile_passed coincide.
REQ-028 tile_passed arriving in CREDIT1 or CREDIT2 is latched in a 1-bit pending flag and processed as a miss in the first PLAY cycle; that miss is counted once even if a new tile_passed also arrives in that cycle.
REQ-029 OVER: game_over=1; increment, miss and tile_clear stay 0; all key events are ignored; startn=0 -> IDLE.
REQ-030 lives never underflows; combo never wraps.

Reset
REQ-031 resetn=0 at a clock edge:
- state <= IDLE;
- increment, tile_clear, miss, game_over <= 0;
- lives <= LIVES; combo <= 0;
- pending flag and synchronizer flops cleared (keys treated as released).
REQ-032 Reset during CREDIT1 or CREDIT2 ends increment at that edge; a partial credit is not completed.
REQ-033 A key held through reset release produces a press event once its synchronized value goes 0->1 (first sample after reset = pressed).

Structure
REQ-034 State encoding and the LIVES default shall live in the shared game package, for reuse by the VGA and control FSMs.
REQ-035 One sub-module, key_sync_edge: a 4-lane synchronizer plus rising-edge detector, parameterised by SYNC_STAGES.
REQ-036 All outputs shall be registered, except tile_clear, which shall be decoded from the registered hit qualification.

Verification
REQ-037 Reset, startn=0 for 1 cycle, tile lane 2 in zone, key_n[2] pressed -> tile_clear 1 cycle, increment high exactly 2 cycles, combo=1, downstream score=1.
REQ-038 Tile lane 1 in zone, key_n[3] pressed -> miss 1 cycle, lives 3->2, combo=0, increment stays 0.
REQ-039 key_n[0] and key_n[1] pressed in the same cycle with a tile in lane 0 -> single miss, no tile_clear.
REQ-040 tile_passed pulsed during CREDIT1 -> miss pulse in the first PLAY cycle; lives decremented by 1 only.
REQ-041 Three misses from LIVES=3 -> game_over=1, lives=0; further keys produce no output; startn=0 -> IDLE, game_over=0.
REQ-042 resetn=0 during CREDIT2 -> increment 0 from the next edge, state IDLE, lives=3, combo=0.
